// File: rtl/dac_pkg.sv
// Shared types and helpers for the SPI DAC transmitter.
// Frame layout: {cfg[3:0], sample[11:0]}, shifted MSB first.
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CS_HOLD,
    LDAC
  } dac_state_e;

  localparam int DAC_FRAME_BITS = 16;
  localparam logic [3:0] DAC_CFG_DEFAULT = 4'b0111;

  // Concatenate the config nibble and the 12-bit code into one frame
  function automatic logic [DAC_FRAME_BITS-1:0] build_frame(
    input logic [3:0]  cfg,
    input logic [11:0] smp
  );
    return {cfg, smp};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK divider: half-period strobes and the registered SCLK level.
// Counters sit at zero whenever en is low, so each frame starts clean.
module dac_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_stb,
  output logic fall_stb,
  output logic last_stb,
  output logic sclk
);

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic [4:0] hp_q, hp_d;
  logic       sclk_q, sclk_d;
  logic       half_end;

  // Half-period end detection and next counter/level values
  always_comb begin
    half_end = en && (div_q == DIV_M1);
    rise_stb = half_end && !sclk_q;
    fall_stb = half_end && sclk_q;
    last_stb = fall_stb && (hp_q == 5'd31);
    div_d    = div_q + 8'd1;
    hp_d     = hp_q;
    sclk_d   = sclk_q;
    if (!en) begin
      div_d  = '0;
      hp_d   = '0;
      sclk_d = 1'b0;
    end else if (half_end) begin
      div_d  = '0;
      hp_d   = hp_q + 5'd1;
      sclk_d = !sclk_q;
    end
  end

  // Divider state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      hp_q   <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      hp_q   <= hp_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/dac_spi_tx.sv
// Serializes one DDS sample per strobe into an MCP4921-style SPI frame.
// Optional LDAC strobe phase: define DAC_LDAC_EN.
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int         AMP_WIDTH      = 12,
  parameter int         CLK_DIV        = 2,
  parameter logic [3:0] CFG_BITS       = DAC_CFG_DEFAULT,
  parameter int         CS_HIGH_CYCLES = 2,
  parameter int         LDAC_CYCLES    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AMP_WIDTH-1:0] sample,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic                 dac_cs_n,
  output logic                 dac_sclk,
  output logic                 dac_mosi,
  output logic                 dac_ldac_n
);

  if (AMP_WIDTH != 12 || CLK_DIV < 1 || CLK_DIV > 255 ||
      CS_HIGH_CYCLES < 1 || LDAC_CYCLES < 1) begin : g_bad_cfg
    $error("dac_spi_tx: illegal parameter set");
  end

  localparam logic [7:0] HOLD_M1 = 8'(CS_HIGH_CYCLES - 1);
`ifdef DAC_LDAC_EN
  localparam logic [7:0] LDAC_M1 = 8'(LDAC_CYCLES - 1);
`endif

  dac_state_e                state_q, state_d;
  logic [DAC_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      cs_n_q, cs_n_d;
  logic                      mosi_q, mosi_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      ovr_q, ovr_d;
`ifdef DAC_LDAC_EN
  logic                      ldac_n_q, ldac_n_d;
`endif

  logic                      accept;
  logic [DAC_FRAME_BITS-1:0] frame;
  logic                      rise_stb, fall_stb, last_stb;
  logic                      sclk;

  dac_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q == SHIFT),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .last_stb (last_stb),
    .sclk     (sclk)
  );

  // Next-state and registered-output logic for the frame FSM
  always_comb begin
    frame   = build_frame(CFG_BITS, sample[11:0]);
    accept  = sample_valid && ready_q;
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    cs_n_d  = cs_n_q;
    mosi_d  = mosi_q;
    ovr_d   = ovr_q || (sample_valid && !ready_q);
`ifdef DAC_LDAC_EN
    ldac_n_d = ldac_n_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = frame;
          cs_n_d  = 1'b0;
          mosi_d  = frame[DAC_FRAME_BITS-1];
        end
      end
      SHIFT: begin
        if (rise_stb) begin
          shreg_d = {shreg_q[DAC_FRAME_BITS-2:0], 1'b0};
        end
        if (last_stb) begin
          state_d = CS_HOLD;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          cnt_d   = '0;
        end else if (fall_stb) begin
          mosi_d = shreg_q[DAC_FRAME_BITS-1];
        end
      end
      CS_HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == HOLD_M1) begin
          cnt_d = '0;
`ifdef DAC_LDAC_EN
          state_d  = LDAC;
          ldac_n_d = 1'b0;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef DAC_LDAC_EN
      LDAC: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LDAC_M1) begin
          cnt_d    = '0;
          ldac_n_d = 1'b1;
          state_d  = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
    // Ready lags the return to IDLE by one cycle and drops on accept
    ready_d = (state_q == IDLE) && !accept;
    busy_d  = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef DAC_LDAC_EN
      ldac_n_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
`ifdef DAC_LDAC_EN
      ldac_n_q <= ldac_n_d;
`endif
    end
  end

  assign sample_ready = ready_q;
  assign busy         = busy_q;
  assign overrun      = ovr_q;
  assign dac_cs_n     = cs_n_q;
  assign dac_sclk     = sclk;
  assign dac_mosi     = mosi_q;
`ifdef DAC_LDAC_EN
  assign dac_ldac_n = ldac_n_q;
`else
  assign dac_ldac_n = 1'b0;
`endif

endmodule
